alu_seq: RTL



---
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, registered result/flags and a shift-add multiplier.
// Define ALU_SEQ_DIV_EN to build the restoring divider (DIV/MOD); otherwise ops 10/11 are illegal.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_MOD  = 4'd11;
`endif

    logic [1:0]       state, state_next;
    logic [3:0]       op_q, op_next;
    logic [WIDTH-1:0] a_q, a_next;
    logic [PW-1:0]    p, p_next;
    logic [SHW-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0] c_next;
    logic [3:0]       flags_next;
    logic             err_next;

    logic [WIDTH-1:0] res;
    logic             res_c, res_v, illegal, multi, div_err;
    logic [WIDTH:0]   sum_w;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   mul_up;
    logic [PW-1:0]    mul_step;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] b_q, b_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] q_step, rem_step;
`endif

    // Next-state, datapath and result computation
    always_comb begin
        state_next = state;
        op_next    = op_q;
        a_next     = a_q;
        p_next     = p;
        cnt_next   = cnt;
        c_next     = c;
        flags_next = flags;
        err_next   = err;
        res        = '0;
        res_c      = 1'b0;
        res_v      = 1'b0;
        illegal    = 1'b0;
        multi      = 1'b0;
        div_err    = 1'b0;
        sum_w      = '0;
        sh         = b[SHW-1:0];
        mul_up     = '0;
        mul_step   = '0;
`ifdef ALU_SEQ_DIV_EN
        b_next     = b_q;
        rem_next   = rem;
        div_shift  = '0;
        div_diff   = '0;
        q_step     = '0;
        rem_step   = '0;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    op_next  = op;
                    a_next   = a;
                    cnt_next = '0;
`ifdef ALU_SEQ_DIV_EN
                    b_next   = b;
`endif
                    case (op)
                        OP_ADD: begin
                            sum_w = {1'b0, a} + {1'b0, b};
                            res   = sum_w[WIDTH-1:0];
                            res_c = sum_w[WIDTH];
                            res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            // top bit of the (WIDTH+1)-bit difference is the borrow
                            sum_w = {1'b0, a} - {1'b0, b};
                            res   = sum_w[WIDTH-1:0];
                            res_c = sum_w[WIDTH];
                            res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND:  res = a & b;
                        OP_OR:   res = a | b;
                        OP_XOR:  res = a ^ b;
                        OP_SHL:  res = a << sh;
                        OP_SHR:  res = a >> sh;
                        OP_SAR:  res = $unsigned($signed(a) >>> sh);
                        OP_MUL, OP_MULH: begin
                            multi  = 1'b1;
                            p_next = {{WIDTH{1'b0}}, b};
                        end
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV, OP_MOD: begin
                            multi    = 1'b1;
                            p_next   = {{WIDTH{1'b0}}, a};
                            rem_next = '0;
                        end
`endif
                        default: illegal = 1'b1;
                    endcase
                    if (multi) begin
                        state_next = S_BUSY;
                    end else begin
                        state_next = S_DONE;
                        c_next     = illegal ? '0 : res;
                        flags_next = illegal ? 4'b0001 : {res_v, res_c, res[WIDTH-1], res == '0};
                        err_next   = illegal;
                    end
                end
            end
            S_BUSY: begin
                cnt_next = cnt + SHW'(1);
                // shift-add multiply: conditionally add a into the high half, then shift right
                mul_up   = p[0] ? ({1'b0, p[PW-1:WIDTH]} + {1'b0, a_q}) : {1'b0, p[PW-1:WIDTH]};
                mul_step = {mul_up, p[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
                // restoring divide: quotient shifts through the low half of p
                div_shift = {rem, p[WIDTH-1]};
                div_diff  = div_shift - {1'b0, b_q};
                if (!div_diff[WIDTH]) begin
                    rem_step = div_diff[WIDTH-1:0];
                    q_step   = {p[WIDTH-2:0], 1'b1};
                end else begin
                    rem_step = div_shift[WIDTH-1:0];
                    q_step   = {p[WIDTH-2:0], 1'b0};
                end
                if (op_q == OP_DIV || op_q == OP_MOD) begin
                    p_next   = {{WIDTH{1'b0}}, q_step};
                    rem_next = rem_step;
                    res      = (op_q == OP_DIV) ? q_step : rem_step;
                    div_err  = (b_q == '0);
                end else
`endif
                begin
                    p_next = mul_step;
                    res    = (op_q == OP_MULH) ? mul_step[PW-1:WIDTH] : mul_step[WIDTH-1:0];
                    res_c  = (op_q == OP_MUL) && (mul_step[PW-1:WIDTH] != '0);
                end
                if (cnt == SHW'(WIDTH - 1)) begin
                    state_next = S_DONE;
                    c_next     = res;
                    flags_next = {1'b0, res_c, res[WIDTH-1], res == '0};
                    err_next   = div_err;
                end
            end
            S_DONE: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            p         <= '0;
            cnt       <= '0;
            c         <= '0;
            flags     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            b_q       <= '0;
            rem       <= '0;
`endif
        end else begin
            state     <= state_next;
            op_q      <= op_next;
            a_q       <= a_next;
            p         <= p_next;
            cnt       <= cnt_next;
            c         <= c_next;
            flags     <= flags_next;
            err       <= err_next;
            out_valid <= (state_next == S_DONE);
            in_ready  <= (state_next == S_IDLE);
`ifdef ALU_SEQ_DIV_EN
            b_q       <= b_next;
            rem       <= rem_next;
`endif
        end
    end

endmodule
